// File: rtl/regfile_pkg.sv
// Shared sizing helpers and the per-port read request layout for the sliced register file.
package regfile_pkg;

    // Defaults for the rjsc5 datapath
    localparam int unsigned DEF_XLEN   = 32;
    localparam int unsigned DEF_NSLICE = 2;
    localparam int unsigned DEF_NREGS  = 32;
    localparam int unsigned DEF_NREAD  = 2;

    // Request fields are sized for the largest supported configuration
    localparam int unsigned REQ_AW = 8;
    localparam int unsigned REQ_LW = 4;

    function automatic int unsigned sw_of(input int unsigned xlen, input int unsigned nslice);
        return xlen / nslice;
    endfunction

    function automatic int unsigned aw_of(input int unsigned nregs);
        return $clog2(nregs);
    endfunction

    function automatic int unsigned lw_of(input int unsigned nslice);
        return $clog2(nslice);
    endfunction

    typedef struct packed {
        logic [REQ_AW-1:0] rs;
        logic [REQ_LW-1:0] slice;
    } rd_req_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-writeback scoreboard: one bit per register, set at issue, cleared by the last slice.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = DEF_NREGS,
    parameter int unsigned NREAD = DEF_NREAD,
    localparam int unsigned AW   = aw_of(NREGS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr_en,
    input  logic [AW-1:0]             clr_rd,
    input  logic                      set_en,
    input  logic [AW-1:0]             set_rd,
    input  logic [NREAD-1:0][AW-1:0]  look_rs,
    output logic [NREAD-1:0]          look_pend_c
);

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;

    // Set after clear so a same-cycle issue owns the register
    always_comb begin
        pending_d = pending_q;
        if (clr_en && (clr_rd != '0)) begin
            pending_d[clr_rd] = 1'b0;
        end
        if (set_en && (set_rd != '0)) begin
            pending_d[set_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // A completing writeback is forwarded to readers; a same-cycle issue is not
    always_comb begin
        look_pend_c = '0;
        for (int unsigned p = 0; p < NREAD; p++) begin
            look_pend_c[p] = pending_q[look_rs[p]] & ~(clr_en && (clr_rd == look_rs[p]));
        end
    end

endmodule

// File: rtl/regfile_sliced.sv
// Sliced register file: one slice written per cycle, NREAD registered operand ports with bypass.
module regfile_sliced
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN   = DEF_XLEN,
    parameter int unsigned NSLICE = DEF_NSLICE,
    parameter int unsigned NREGS  = DEF_NREGS,
    parameter int unsigned NREAD  = DEF_NREAD,
    localparam int unsigned SW    = sw_of(XLEN, NSLICE),
    localparam int unsigned AW    = aw_of(NREGS),
    localparam int unsigned LW    = lw_of(NSLICE)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rw_clken,
    input  logic [LW-1:0]             rw_slice,
    input  logic                      rw_last,
    input  logic [AW-1:0]             rw_rd,
    input  logic [SW-1:0]             rw_result,
    input  logic                      ex_clken,
    input  logic [NREAD-1:0][AW-1:0]  de_rs,
    input  logic [NREAD-1:0][LW-1:0]  de_slice,
    input  logic                      de_issue,
    input  logic [AW-1:0]             de_rd,
    output logic [NREAD-1:0][SW-1:0]  ex_src,
    output logic [NREAD-1:0]          ex_pending
);

    logic [SW-1:0] mem_q [NREGS][NSLICE];

    rd_req_t [NREAD-1:0]         req_c;
    logic    [NREAD-1:0][AW-1:0] look_rs_c;
    logic    [NREAD-1:0][SW-1:0] rd_data_c;
    logic    [NREAD-1:0]         sb_pend_c;
    logic                        wr_en_c;

    logic [NREAD-1:0][SW-1:0]    ex_src_q;
    logic [NREAD-1:0][SW-1:0]    ex_src_d;
    logic [NREAD-1:0]            ex_pending_q;
    logic [NREAD-1:0]            ex_pending_d;

    assign wr_en_c = rw_clken && (rw_rd != '0);

    // Array write; contents deliberately not reset so the array maps onto RAM
    always_ff @(posedge clk) begin
        if (reset && wr_en_c) begin
            mem_q[rw_rd][rw_slice] <= rw_result;
        end
    end

    // Per-port read with r0 forced to zero and same-slice write bypass
    always_comb begin
        req_c     = '0;
        look_rs_c = '0;
        rd_data_c = '0;
        for (int unsigned p = 0; p < NREAD; p++) begin
            req_c[p].rs    = REQ_AW'(de_rs[p]);
            req_c[p].slice = REQ_LW'(de_slice[p]);
            look_rs_c[p]   = AW'(req_c[p].rs);
            if (req_c[p].rs == '0) begin
                rd_data_c[p] = '0;
            end else if (wr_en_c && (req_c[p].rs == REQ_AW'(rw_rd))
                         && (req_c[p].slice == REQ_LW'(rw_slice))) begin
                rd_data_c[p] = rw_result;
            end else begin
                rd_data_c[p] = mem_q[AW'(req_c[p].rs)][LW'(req_c[p].slice)];
            end
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NREAD (NREAD)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .clr_en      (rw_clken && rw_last),
        .clr_rd      (rw_rd),
        .set_en      (ex_clken && de_issue),
        .set_rd      (de_rd),
        .look_rs     (look_rs_c),
        .look_pend_c (sb_pend_c)
    );

    always_comb begin
        ex_src_d     = ex_src_q;
        ex_pending_d = ex_pending_q;
        if (ex_clken) begin
            ex_src_d     = rd_data_c;
            ex_pending_d = sb_pend_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_src_q     <= '0;
            ex_pending_q <= '0;
        end else begin
            ex_src_q     <= ex_src_d;
            ex_pending_q <= ex_pending_d;
        end
    end

    assign ex_src     = ex_src_q;
    assign ex_pending = ex_pending_q;

endmodule

// File: tb/tb_regfile_sliced.sv
// Directed bench for regfile_sliced at default parameters (SW=16, AW=5, LW=1, two ports).
module tb_regfile_sliced;

    logic             clk = 1'b0;
    logic             reset;
    logic             rw_clken;
    logic [0:0]       rw_slice;
    logic             rw_last;
    logic [4:0]       rw_rd;
    logic [15:0]      rw_result;
    logic             ex_clken;
    logic [1:0][4:0]  de_rs;
    logic [1:0][0:0]  de_slice;
    logic             de_issue;
    logic [4:0]       de_rd;
    logic [1:0][15:0] ex_src;
    logic [1:0]       ex_pending;

    int total = 0;
    int bad   = 0;

    regfile_sliced dut (
        .clk        (clk),
        .reset      (reset),
        .rw_clken   (rw_clken),
        .rw_slice   (rw_slice),
        .rw_last    (rw_last),
        .rw_rd      (rw_rd),
        .rw_result  (rw_result),
        .ex_clken   (ex_clken),
        .de_rs      (de_rs),
        .de_slice   (de_slice),
        .de_issue   (de_issue),
        .de_rd      (de_rd),
        .ex_src     (ex_src),
        .ex_pending (ex_pending)
    );

    always #5 clk = ~clk;

    task automatic idle();
        rw_clken  = 1'b0;
        rw_slice  = '0;
        rw_last   = 1'b0;
        rw_rd     = '0;
        rw_result = '0;
        ex_clken  = 1'b0;
        de_rs     = '0;
        de_slice  = '0;
        de_issue  = 1'b0;
        de_rd     = '0;
    endtask

    task automatic wr(input logic [4:0] rd, input logic sl, input logic [15:0] data, input logic last);
        rw_clken  = 1'b1;
        rw_rd     = rd;
        rw_slice  = sl;
        rw_result = data;
        rw_last   = last;
    endtask

    task automatic rd(input logic [4:0] rs0, input logic sl0, input logic [4:0] rs1, input logic sl1);
        ex_clken    = 1'b1;
        de_rs[0]    = rs0;
        de_slice[0] = sl0;
        de_rs[1]    = rs1;
        de_slice[1] = sl1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        wr(5'd5, 1'b0, 16'hDEAD, 1'b1);
        rd(5'd5, 1'b0, 5'd5, 1'b1);
        de_issue = 1'b1;
        de_rd    = 5'd6;
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++;
            if ({ex_src, ex_pending} !== 34'h0) begin
                bad++;
                $display("FAIL reset_hold cyc%0d: got src=%h pend=%b, want 0/00", i, ex_src, ex_pending);
            end
        end
        reset = 1'b1;
        idle();
        rd(5'd0, 1'b0, 5'd6, 1'b1);
        cyc();
        total++;
        if (ex_src[0] !== 16'h0 || ex_pending !== 2'b00) begin
            bad++;
            $display("FAIL reset_r0_read: got src0=%h pend=%b, want 0000/00", ex_src[0], ex_pending);
        end
    endtask

    task automatic test_write_read();
        idle(); wr(5'd5, 1'b0, 16'h1234, 1'b0); cyc();
        idle(); wr(5'd5, 1'b1, 16'hABCD, 1'b1); cyc();
        idle(); rd(5'd5, 1'b1, 5'd5, 1'b0); cyc();
        total++;
        if (ex_src[0] !== 16'hABCD || ex_src[1] !== 16'h1234 || ex_pending !== 2'b00) begin
            bad++;
            $display("FAIL write_read: got %h/%h pend=%b, want abcd/1234 00", ex_src[0], ex_src[1], ex_pending);
        end
    endtask

    task automatic test_bypass();
        idle(); wr(5'd7, 1'b1, 16'h0F0F, 1'b1); cyc();
        idle(); wr(5'd7, 1'b0, 16'h5555, 1'b0); rd(5'd7, 1'b0, 5'd7, 1'b1); cyc();
        total++;
        if (ex_src[0] !== 16'h5555 || ex_src[1] !== 16'h0F0F || ex_pending !== 2'b00) begin
            bad++;
            $display("FAIL bypass: got %h/%h pend=%b, want 5555/0f0f 00", ex_src[0], ex_src[1], ex_pending);
        end
        idle(); rd(5'd7, 1'b0, 5'd0, 1'b0); cyc();
        total++;
        if (ex_src[0] !== 16'h5555 || ex_src[1] !== 16'h0000) begin
            bad++;
            $display("FAIL bypass_stored: got %h/%h, want 5555/0000", ex_src[0], ex_src[1]);
        end
    endtask

    task automatic test_scoreboard();
        idle(); rd(5'd0, 1'b0, 5'd3, 1'b0); de_issue = 1'b1; de_rd = 5'd3; cyc();
        total++;
        if (ex_pending !== 2'b00) begin
            bad++;
            $display("FAIL sb_own_issue: got pend=%b, want 00", ex_pending);
        end
        idle(); rd(5'd3, 1'b0, 5'd3, 1'b1); cyc();
        total++;
        if (ex_pending !== 2'b11) begin
            bad++;
            $display("FAIL sb_pending: got pend=%b, want 11", ex_pending);
        end
        idle(); wr(5'd3, 1'b0, 16'h1111, 1'b0); rd(5'd3, 1'b0, 5'd3, 1'b1); cyc();
        total++;
        if (ex_pending !== 2'b11 || ex_src[0] !== 16'h1111) begin
            bad++;
            $display("FAIL sb_nonlast: got pend=%b src0=%h, want 11/1111", ex_pending, ex_src[0]);
        end
        idle(); wr(5'd3, 1'b1, 16'h2222, 1'b1); rd(5'd3, 1'b1, 5'd3, 1'b0); cyc();
        total++;
        if (ex_pending !== 2'b00 || ex_src[0] !== 16'h2222 || ex_src[1] !== 16'h1111) begin
            bad++;
            $display("FAIL sb_last_fwd: got pend=%b %h/%h, want 00 2222/1111", ex_pending, ex_src[0], ex_src[1]);
        end
        idle(); rd(5'd3, 1'b0, 5'd3, 1'b1); cyc();
        total++;
        if (ex_pending !== 2'b00 || ex_src[0] !== 16'h1111 || ex_src[1] !== 16'h2222) begin
            bad++;
            $display("FAIL sb_cleared: got pend=%b %h/%h, want 00 1111/2222", ex_pending, ex_src[0], ex_src[1]);
        end
    endtask

    task automatic test_collision();
        idle(); rd(5'd0, 1'b0, 5'd0, 1'b0); de_issue = 1'b1; de_rd = 5'd9; cyc();
        idle(); wr(5'd9, 1'b0, 16'h9999, 1'b1); rd(5'd9, 1'b0, 5'd0, 1'b0);
        de_issue = 1'b1; de_rd = 5'd9; cyc();
        total++;
        if (ex_pending !== 2'b00 || ex_src[0] !== 16'h9999) begin
            bad++;
            $display("FAIL coll_same_cycle: got pend=%b src0=%h, want 00/9999", ex_pending, ex_src[0]);
        end
        idle(); rd(5'd9, 1'b0, 5'd9, 1'b1); cyc();
        total++;
        if (ex_pending !== 2'b11) begin
            bad++;
            $display("FAIL coll_set_wins: got pend=%b, want 11", ex_pending);
        end
        idle(); wr(5'd0, 1'b0, 16'hFFFF, 1'b1); rd(5'd0, 1'b0, 5'd0, 1'b1);
        de_issue = 1'b1; de_rd = 5'd0; cyc();
        total++;
        if (ex_src !== 32'h0 || ex_pending !== 2'b00) begin
            bad++;
            $display("FAIL r0_write_bypass: got src=%h pend=%b, want 0/00", ex_src, ex_pending);
        end
        idle(); rd(5'd0, 1'b0, 5'd0, 1'b1); cyc();
        total++;
        if (ex_src !== 32'h0 || ex_pending !== 2'b00) begin
            bad++;
            $display("FAIL r0_issue: got src=%h pend=%b, want 0/00", ex_src, ex_pending);
        end
    endtask

    task automatic test_hold();
        idle(); rd(5'd9, 1'b0, 5'd5, 1'b0); cyc();
        total++;
        if (ex_src[0] !== 16'h9999 || ex_src[1] !== 16'h1234 || ex_pending !== 2'b01) begin
            bad++;
            $display("FAIL hold_load: got %h/%h pend=%b, want 9999/1234 01", ex_src[0], ex_src[1], ex_pending);
        end
        idle(); de_rs[0] = 5'd5; de_slice[0] = 1'b1; de_rs[1] = 5'd0;
        wr(5'd9, 1'b0, 16'h7777, 1'b1); cyc();
        total++;
        if (ex_src[0] !== 16'h9999 || ex_src[1] !== 16'h1234 || ex_pending !== 2'b01) begin
            bad++;
            $display("FAIL hold_cyc1: got %h/%h pend=%b, want 9999/1234 01", ex_src[0], ex_src[1], ex_pending);
        end
        idle(); de_rs[0] = 5'd7; de_rs[1] = 5'd3; cyc();
        total++;
        if (ex_src[0] !== 16'h9999 || ex_src[1] !== 16'h1234 || ex_pending !== 2'b01) begin
            bad++;
            $display("FAIL hold_cyc2: got %h/%h pend=%b, want 9999/1234 01", ex_src[0], ex_src[1], ex_pending);
        end
    endtask

    task automatic test_reset_mid();
        idle(); rd(5'd0, 1'b0, 5'd0, 1'b0); de_issue = 1'b1; de_rd = 5'd4; cyc();
        idle(); wr(5'd4, 1'b0, 16'h4444, 1'b0); rd(5'd4, 1'b0, 5'd4, 1'b1); cyc();
        total++;
        if (ex_pending !== 2'b11 || ex_src[0] !== 16'h4444) begin
            bad++;
            $display("FAIL mid_pending: got pend=%b src0=%h, want 11/4444", ex_pending, ex_src[0]);
        end
        reset = 1'b0;
        idle(); wr(5'd4, 1'b1, 16'hBEEF, 1'b1); rd(5'd4, 1'b0, 5'd4, 1'b0); cyc();
        total++;
        if (ex_src !== 32'h0 || ex_pending !== 2'b00) begin
            bad++;
            $display("FAIL mid_reset: got src=%h pend=%b, want 0/00", ex_src, ex_pending);
        end
        reset = 1'b1;
        idle(); rd(5'd4, 1'b0, 5'd4, 1'b0); cyc();
        total++;
        if (ex_src[0] !== 16'h4444 || ex_src[1] !== 16'h4444 || ex_pending !== 2'b00) begin
            bad++;
            $display("FAIL mid_after: got %h/%h pend=%b, want 4444/4444 00", ex_src[0], ex_src[1], ex_pending);
        end
    endtask

    initial begin
        reset = 1'b0;
        idle();
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_collision();
        test_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_sliced.md
Name: regfile_sliced

Overview:
- Parametrised sliced register file for the rjsc5 datapath; successor to the fixed two-instance half-register arrangement.
- One shared array of NREGS x XLEN registers, written one SW-bit slice per cycle from the RW stage.
- Read by NREAD ports into registered EX-stage operands, with write-to-read bypass.
- Integrated pending-write scoreboard reports per port whether the source register still has an outstanding multi-slice writeback.

Parameters:
- XLEN, 32, architectural register width.
- NSLICE, 2, slices per register; power of two, >= 2.
- NREGS, 32, number of registers; power of two; register 0 hardwired zero.
- NREAD, 2, number of read ports.
- Derived: SW = XLEN/NSLICE, AW = $clog2(NREGS), LW = $clog2(NSLICE).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- rw_clken  in  1  writeback slice valid this cycle
- rw_slice  in  LW  slice index being written
- rw_last  in  1  final slice of this writeback; clears pending
- rw_rd  in  AW  destination register
- rw_result  in  SW  slice data
- ex_clken  in  1  EX operand register enable
- de_rs  in  NREAD x AW  source register per port
- de_slice  in  NREAD x LW  slice requested per port
- de_issue  in  1  instruction with destination issues (qualified by ex_clken)
- de_rd  in  AW  destination of issuing instruction
- ex_src  out  NREAD x SW  registered operand slice per port
- ex_pending  out  NREAD  registered: source had outstanding writeback at read

Behaviour:
- Reset (reset==0 at a clk edge):
  - ex_src = 0 and ex_pending = 0.
  - All scoreboard bits cleared.
  - Writes and issues in that cycle are ignored; reset dominates both clock enables.
  - Array contents are not reset (RAM-inferable); register 0 always reads 0.
- Write:
  - At an edge with rw_clken=1 and rw_rd!=0, slice rw_slice of register rw_rd takes rw_result.
  - Other slices of that register are unchanged.
  - rw_rd==0 is a no-op.
- Read (latency 1): at an edge with ex_clken=1, for each port p, ex_src[p] takes slice de_slice[p] of register de_rs[p].
  - de_rs[p]==0 yields 0.
  - Bypass: if rw_clken=1, rw_rd==de_rs[p], rw_rd!=0 and rw_slice==de_slice[p], ex_src[p] takes rw_result (new data, not the array value).
  - With ex_clken=0, ex_src and ex_pending hold.
- Scoreboard (one bit per register; bit 0 is constant 0):
  - Clear: rw_clken & rw_last & rw_rd!=0 clears pending[rw_rd].
  - Set: ex_clken & de_issue & de_rd!=0 sets pending[de_rd].
  - Same register cleared and set in the same cycle: set wins, so the new instruction owns the register.
  - ex_pending[p] (updated only when ex_clken=1) = pending[de_rs[p]] & ~(rw_clken & rw_last & rw_rd==de_rs[p]). A completing writeback is visible to readers in the same cycle.
  - An issue to de_rd in the same cycle as a read of that register reports the pre-issue state; a read never sees its own instruction's destination.
- Ordering and boundaries:
  - Any number of ports may read the same register or slice simultaneously; all get identical data.
  - Non-last slice writes do not change pending.
  - A write to a non-pending register is legal and leaves pending at 0.
  - Reset asserted mid-writeback discards the remaining pending state; partially written slices stay in the array.

Decomposition:
- Package regfile_pkg holds:
  - functions/localparams for SW, AW, LW from XLEN/NSLICE/NREGS;
  - the typedef for the packed per-port read request {rs, slice}.
- Sub-module regfile_scoreboard (NREGS, NREAD) holds:
  - the pending-bit vector and its set/clear logic;
  - the per-port combinational lookup with same-cycle clear forwarding.
- The top instantiates the scoreboard; the array, bypass muxes and ex_* registers stay in the top.

Test Plan:
- Reset with ex_clken=1, rw_clken=1: ex_src=0 and ex_pending=0 throughout. After release, read r0 on both ports -> 0.
- Write r5 slice0=0x1234 then slice1=0xABCD (rw_last=1); next cycle read port0 r5/slice1 and port1 r5/slice0 -> 0xABCD and 0x1234, ex_pending=0.
- Same-cycle bypass: write r7 slice0=0x5555 while port0 reads r7/slice0 and port1 reads r7/slice1 (previously 0x0F0F) -> 0x5555 and 0x0F0F.
- Scoreboard:
  - Issue de_rd=3.
  - Next cycle read r3 -> ex_pending=1.
  - Write slice0 (rw_last=0) and read r3 -> still 1.
  - Write slice1 (rw_last=1) and read r3 in the same cycle -> ex_pending=0, slice1 bypassed.
- Collision: in one cycle, rw_last clears r9 while de_issue sets r9 -> following read of r9 reports ex_pending=1. Issue to r0 -> reads of r0 report 0.
- Hold, then reset: ex_clken=0 while de_rs changes -> ex_src/ex_pending unchanged. Assert reset mid-writeback with r4 pending -> after release, read r4 -> ex_pending=0.
